// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller:
// cause codes, FSM states and pending-vector bit positions.
package trap_pkg;

    typedef enum logic [2:0] {
        CAUSE_NMI    = 3'd0,
        CAUSE_EBREAK = 3'd1,
        CAUSE_ECALL  = 3'd2,
        CAUSE_TMR    = 3'd3,
        CAUSE_EXT    = 3'd4
    } cause_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TAKE,
        S_HANDLER,
        S_RETURN
    } state_e;

    localparam int NUM_SRC  = 5;
    localparam int P_NMI    = 0;
    localparam int P_EBREAK = 1;
    localparam int P_ECALL  = 2;
    localparam int P_TMR    = 3;
    localparam int P_EXT    = 4;

endpackage

// File: rtl/trap_priority_encoder.sv
// Fixed-priority pick over the masked pending vector;
// the lowest set bit index is the winning cause code.
module trap_priority_encoder
    import trap_pkg::*;
(
    input  logic [NUM_SRC-1:0] pend,
    output logic               valid,
    output logic [2:0]         cause
);

    always_comb begin
        valid = |pend;
        cause = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                cause = 3'(i);
            end
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap entry/return sequencer: latches sources, picks a winner
// at a commit boundary, writes MEPC and redirects fetch to the vector.
module trap_controller
    import trap_pkg::*;
#(
    parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
    parameter int          VEC_SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nmi,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        ext_int,
    input  logic        tmr_int,
    input  logic [3:0]  mie,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        mret,
    input  logic [31:0] epc,
    output logic        stall,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        epc_we,
    output logic [31:0] epc_wdata,
    output logic [2:0]  cause,
    output logic [4:0]  pending,
    output logic        in_trap
);

    state_e      state_q, state_d;
    cause_e      cause_q, cause_d;
    logic [31:0] saved_q, saved_d;
    logic        nmi_lat_q, nmi_lat_d;
    logic        tmr_lat_q, tmr_lat_d;
    logic        nmi_prev_q, nmi_prev_d;
    logic        ext_q, ext_d;

    logic [NUM_SRC-1:0] pend;
    logic               win_valid;
    logic [2:0]         win_cause;
    logic               commit_ok;
    logic               sw_ok;

    // Instruction-borne requests only count while idle at a real commit.
    always_comb begin
        commit_ok       = commit_valid && (state_q == S_IDLE);
        sw_ok           = mie[2] && mie[3];
        pend            = '0;
        pend[P_NMI]     = nmi_lat_q;
        pend[P_EBREAK]  = commit_ok && ebreak && sw_ok;
        pend[P_ECALL]   = commit_ok && ecall && sw_ok;
        pend[P_TMR]     = tmr_lat_q && mie[0] && mie[3];
        pend[P_EXT]     = ext_q && mie[1] && mie[3];
    end

    trap_priority_encoder u_prio (
        .pend  (pend),
        .valid (win_valid),
        .cause (win_cause)
    );

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        saved_d     = saved_q;
        nmi_lat_d   = nmi_lat_q;
        tmr_lat_d   = tmr_lat_q;
        nmi_prev_d  = nmi;
        ext_d       = ext_int;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        epc_we      = 1'b0;
        epc_wdata   = 32'd0;
        in_trap     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (commit_valid && win_valid) begin
                    state_d = S_TAKE;
                    cause_d = cause_e'(win_cause);
                    saved_d = commit_pc;
                end
            end
            S_TAKE: begin
                stall       = 1'b1;
                flush       = 1'b1;
                redirect    = 1'b1;
                epc_we      = 1'b1;
                epc_wdata   = saved_q;
                redirect_pc = VEC_BASE + (32'(cause_q) << VEC_SHIFT);
                if (cause_q == CAUSE_NMI) nmi_lat_d = 1'b0;
                if (cause_q == CAUSE_TMR) tmr_lat_d = 1'b0;
                state_d     = S_HANDLER;
            end
            S_HANDLER: begin
                in_trap = 1'b1;
                if (commit_valid && mret) begin
                    state_d = S_RETURN;
                end
            end
            S_RETURN: begin
                stall       = 1'b1;
                flush       = 1'b1;
                redirect    = 1'b1;
                // Synchronous exceptions resume past the faulting instruction.
                if (cause_q == CAUSE_EBREAK || cause_q == CAUSE_ECALL) begin
                    redirect_pc = epc + 32'd4;
                end else begin
                    redirect_pc = epc;
                end
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (nmi && !nmi_prev_q) nmi_lat_d = 1'b1;
        if (tmr_int)            tmr_lat_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cause_q    <= CAUSE_NMI;
            saved_q    <= 32'd0;
            nmi_lat_q  <= 1'b0;
            tmr_lat_q  <= 1'b0;
            nmi_prev_q <= 1'b0;
            ext_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            saved_q    <= saved_d;
            nmi_lat_q  <= nmi_lat_d;
            tmr_lat_q  <= tmr_lat_d;
            nmi_prev_q <= nmi_prev_d;
            ext_q      <= ext_d;
        end
    end

    assign cause   = cause_q;
    assign pending = pend;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller with a cycle-level reference
// model and literal spot checks of the key addresses.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        nmi, ecall, ebreak, ext_int, tmr_int;
    logic [3:0]  mie;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        mret;
    logic [31:0] epc;
    logic        stall, flush, redirect, epc_we, in_trap;
    logic [31:0] redirect_pc, epc_wdata;
    logic [2:0]  cause;
    logic [4:0]  pending;

    int n_chk  = 0;
    int n_fail = 0;

    trap_controller dut (
        .clk          (clk),
        .rst          (rst),
        .nmi          (nmi),
        .ecall        (ecall),
        .ebreak       (ebreak),
        .ext_int      (ext_int),
        .tmr_int      (tmr_int),
        .mie          (mie),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .mret         (mret),
        .epc          (epc),
        .stall        (stall),
        .flush        (flush),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .epc_we       (epc_we),
        .epc_wdata    (epc_wdata),
        .cause        (cause),
        .pending      (pending),
        .in_trap      (in_trap)
    );

    always #5 clk = ~clk;

    // Reference model: what the controller is doing this cycle.
    bit          m_live = 0;
    bit          e_take = 0, e_ret = 0, e_hdl = 0;
    logic [2:0]  m_cause = 3'd0;
    logic [31:0] e_wdata = 32'd0;
    bit          m_nmi_pend = 0, m_tmr_pend = 0;
    bit          m_nmi_last = 0, m_ext_last = 0;

    function automatic logic [4:0] m_pend();
        logic [4:0] p;
        bit idle;
        idle = !(e_take || e_ret || e_hdl);
        p[0] = m_nmi_pend;
        p[1] = idle && commit_valid && ebreak && mie[2] && mie[3];
        p[2] = idle && commit_valid && ecall && mie[2] && mie[3];
        p[3] = m_tmr_pend && mie[0] && mie[3];
        p[4] = m_ext_last && mie[1] && mie[3];
        return p;
    endfunction

    always @(posedge clk) begin : model
        logic [4:0] p;
        int w;
        bit rise;
        if (!rst) begin
            m_live     <= 1;
            e_take     <= 0;
            e_ret      <= 0;
            e_hdl      <= 0;
            m_cause    <= 3'd0;
            e_wdata    <= 32'd0;
            m_nmi_pend <= 0;
            m_tmr_pend <= 0;
            m_nmi_last <= 0;
            m_ext_last <= 0;
        end else begin
            p    = m_pend();
            rise = nmi && !m_nmi_last;
            m_nmi_pend <= rise ? 1'b1 :
                          (e_take && m_cause == 3'd0) ? 1'b0 : m_nmi_pend;
            m_tmr_pend <= tmr_int ? 1'b1 :
                          (e_take && m_cause == 3'd3) ? 1'b0 : m_tmr_pend;
            m_nmi_last <= nmi;
            m_ext_last <= ext_int;
            if (e_take) begin
                e_take <= 0;
                e_hdl  <= 1;
            end else if (e_ret) begin
                e_ret <= 0;
            end else if (e_hdl) begin
                if (commit_valid && mret) begin
                    e_hdl <= 0;
                    e_ret <= 1;
                end
            end else if (commit_valid && p != 5'd0) begin
                w = 0;
                while (!p[w]) w++;
                m_cause <= 3'(w);
                e_wdata <= commit_pc;
                e_take  <= 1;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [76:0] got, exp;
        logic [31:0] rpc;
        if (m_live) begin
            rpc = 32'd0;
            if (e_take) rpc = 32'h100 + 32'(m_cause) * 32'd16;
            if (e_ret)  rpc = epc + ((m_cause == 3'd1 || m_cause == 3'd2) ? 32'd4 : 32'd0);
            exp = {e_take || e_ret, e_take || e_ret, e_take || e_ret, e_take, e_hdl,
                   rpc, e_take ? e_wdata : 32'd0, m_cause, m_pend()};
            got = {stall, flush, redirect, epc_we, in_trap,
                   redirect_pc, epc_wdata, cause, pending};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, got, exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_mret(input logic [31:0] e);
        commit_valid = 1; mret = 1; epc = e;
        step();
        commit_valid = 0; mret = 0;
    endtask

    initial begin
        rst = 0; nmi = 0; ecall = 0; ebreak = 0; ext_int = 0; tmr_int = 0;
        mie = 4'b1111; commit_valid = 0; commit_pc = 0; mret = 0; epc = 0;
        step(); step();
        chk("reset_flags", {27'd0, stall, flush, redirect, epc_we, in_trap}, 32'd0);
        chk("reset_rpc", redirect_pc, 32'd0);
        chk("reset_cause_pend", {24'd0, cause, pending}, 32'd0);
        rst = 1;
        step();

        // Timer trap and return to the interrupted PC.
        tmr_int = 1; step(); tmr_int = 0;
        commit_valid = 1; commit_pc = 32'h200; step(); commit_valid = 0;
        chk("tmr_take_flags", {28'd0, flush, redirect, epc_we, stall}, 32'hF);
        chk("tmr_wdata", epc_wdata, 32'h200);
        chk("tmr_vec", redirect_pc, 32'h130);
        chk("tmr_cause", {29'd0, cause}, 32'd3);
        step();
        chk("tmr_in_trap", {31'd0, in_trap}, 32'd1);
        do_mret(32'h200);
        chk("tmr_ret_pc", redirect_pc, 32'h200);
        step();

        // ECALL returns past the instruction.
        commit_valid = 1; ecall = 1; commit_pc = 32'h400; step();
        commit_valid = 0; ecall = 0;
        chk("ecall_vec", redirect_pc, 32'h120);
        step(); step();
        do_mret(32'h400);
        chk("ecall_ret_pc", redirect_pc, 32'h404);
        step();

        // NMI beats EXT and ECALL; EXT taken after return.
        nmi = 1; ext_int = 1; step();
        commit_valid = 1; ecall = 1; commit_pc = 32'h500; step();
        commit_valid = 0; ecall = 0; nmi = 0;
        chk("prio_cause", {29'd0, cause}, 32'd0);
        chk("prio_vec", redirect_pc, 32'h100);
        step();
        do_mret(32'h500);
        chk("nmi_ret_pc", redirect_pc, 32'h500);
        step();
        commit_valid = 1; commit_pc = 32'h504; step(); commit_valid = 0;
        chk("ext_cause", {29'd0, cause}, 32'd4);
        chk("ext_vec", redirect_pc, 32'h140);
        ext_int = 0;
        step();
        do_mret(32'h504);
        step();

        // Global disable masks TMR/EXT but not NMI.
        mie = 4'b0111; ext_int = 1; tmr_int = 1; step(); tmr_int = 0;
        commit_valid = 1; commit_pc = 32'h600; step();
        chk("mask_no_trap", {30'd0, redirect, in_trap}, 32'd0);
        chk("mask_pending", {27'd0, pending}, 32'd0);
        commit_valid = 0; nmi = 1; step();
        commit_valid = 1; commit_pc = 32'h700; step();
        commit_valid = 0; nmi = 0; ext_int = 0;
        chk("mask_nmi_vec", redirect_pc, 32'h100);
        step();
        do_mret(32'h700);
        step();
        commit_valid = 1; commit_pc = 32'h704; step(); commit_valid = 0;
        chk("mask_tmr_held", {30'd0, redirect, in_trap}, 32'd0);
        mie = 4'b1111; step();
        chk("tmr_latched", {27'd0, pending}, 32'h08);
        commit_valid = 1; step(); commit_valid = 0;
        chk("late_tmr_vec", redirect_pc, 32'h130);
        step();
        do_mret(32'h704);
        step();

        // MRET collides with a new NMI edge; RETURN wins.
        commit_valid = 1; ebreak = 1; commit_pc = 32'h800; step();
        commit_valid = 0; ebreak = 0;
        chk("ebreak_vec", redirect_pc, 32'h110);
        tmr_int = 1; step(); tmr_int = 0;
        nmi = 1;
        do_mret(32'h800);
        chk("coll_ret_pc", redirect_pc, 32'h804);
        step();
        chk("coll_pending", {27'd0, pending}, 32'h09);
        commit_valid = 1; commit_pc = 32'h804; step();
        commit_valid = 0; nmi = 0;
        chk("coll_nmi_vec", redirect_pc, 32'h100);

        // Reset in the middle of TAKE.
        rst = 0; step();
        chk("rst_take_flags", {27'd0, stall, flush, redirect, epc_we, in_trap}, 32'd0);
        chk("rst_take_pend", {24'd0, cause, pending}, 32'd0);
        rst = 1; step();
        chk("rst_idle", {26'd0, in_trap, pending}, 32'd0);

        // Return address wraps modulo 2^32.
        commit_valid = 1; ecall = 1; commit_pc = 32'hFFFF_FFFC; step();
        commit_valid = 0; ecall = 0;
        chk("wrap_wdata", epc_wdata, 32'hFFFF_FFFC);
        step();
        do_mret(32'hFFFF_FFFC);
        chk("wrap_ret_pc", redirect_pc, 32'h0);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
